// File: rtl/vec_regfile_mp_if.sv
// Bus bundle for vec_regfile_mp: decode-side reads/scoreboard, writeback-side writes and clear.
interface vec_regfile_mp_if #(
  parameter int unsigned LANES = 6,
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 10
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                       clear_req;
  logic                       ready;
  logic                       we;
  logic [AW-1:0]              wa;
  logic [LANES-1:0][W-1:0]    wd;
  logic [LANES-1:0]           wmask;
  logic [AW-1:0]              ra1;
  logic [AW-1:0]              ra2;
  logic [LANES-1:0][W-1:0]    rd1;
  logic [LANES-1:0][W-1:0]    rd2;
  logic                       busy_set;
  logic [AW-1:0]              busy_addr;
  logic                       busy1;
  logic                       busy2;

  modport master (
    output clear_req, we, wa, wd, wmask, ra1, ra2, busy_set, busy_addr,
    input  ready, rd1, rd2, busy1, busy2
  );

  modport slave (
    input  clear_req, we, wa, wd, wmask, ra1, ra2, busy_set, busy_addr,
    output ready, rd1, rd2, busy1, busy2
  );
endinterface

// File: rtl/vec_regfile_mp.sv
// Vector register file with lane masking, optional bypass, pending-write scoreboard,
// optional hard-wired zero register and a sequenced clear sweep.
module vec_regfile_mp #(
  parameter int unsigned LANES   = 6,
  parameter int unsigned W       = 8,
  parameter int unsigned DEPTH   = 10,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  vec_regfile_mp_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [LANES-1:0][W-1:0] vec_t;
  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DEPTH-1:0] sb_q, sb_d;
  vec_t            rf_q [DEPTH];

  logic            run;
  logic            wr_ok;
  logic            bs_ok;
  logic [AW-1:0]   wa_idx;
  logic [AW-1:0]   ba_idx;
  logic [AW-1:0]   ra   [2];
  vec_t            rd   [2];
  logic            busy [2];

  function automatic logic in_range(logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(DEPTH));
  endfunction

  function automatic logic is_r0(logic [AW-1:0] a);
    return ZERO_R0 && (a == '0);
  endfunction

  // Out-of-range addresses are folded to 0 so array indices always stay in bounds.
  function automatic logic [AW-1:0] safe_idx(logic [AW-1:0] a);
    return in_range(a) ? a : '0;
  endfunction

  assign run    = (state_q == StRun);
  assign wa_idx = safe_idx(bus.wa);
  assign ba_idx = safe_idx(bus.busy_addr);
  // clear_req wins over any write or busy_set on the same edge.
  assign wr_ok  = run && !bus.clear_req && bus.we && in_range(bus.wa) && !is_r0(bus.wa);
  assign bs_ok  = run && !bus.clear_req && bus.busy_set && in_range(bus.busy_addr) &&
                  !is_r0(bus.busy_addr);

  // State, sweep pointer and scoreboard registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
      sb_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      sb_q      <= sb_d;
    end
  end

  // Next-state: sweep through all registers in CLEAR; scoreboard updates in RUN.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    sb_d      = sb_q;
    unique case (state_q)
      StClear: begin
        if (clr_ptr_q == AW'(DEPTH - 1)) begin
          state_d   = StRun;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + AW'(1);
        end
      end
      StRun: begin
        if (bus.clear_req) begin
          state_d   = StClear;
          clr_ptr_d = '0;
          sb_d      = '0;
        end else begin
          if (wr_ok) sb_d[wa_idx] = 1'b0;
          // Set after clear so a newly issued producer wins.
          if (bs_ok) sb_d[ba_idx] = 1'b1;
        end
      end
      default: state_d = StClear;
    endcase
  end

  // Register array: zeroed one entry per edge during the sweep, masked lane writes in RUN.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == StClear) begin
        rf_q[clr_ptr_q] <= '0;
      end else if (wr_ok) begin
        for (int i = 0; i < int'(LANES); i++) begin
          if (bus.wmask[i]) rf_q[wa_idx][i] <= bus.wd[i];
        end
      end
    end
  end

  assign ra[0] = bus.ra1;
  assign ra[1] = bus.ra2;

  // Combinational read ports with optional same-cycle write bypass.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p]   = '0;
      busy[p] = 1'b0;
      if (run && in_range(ra[p]) && !is_r0(ra[p])) begin
        rd[p]   = rf_q[safe_idx(ra[p])];
        busy[p] = sb_q[safe_idx(ra[p])];
        if (BYPASS && wr_ok && (bus.wa == ra[p])) begin
          for (int i = 0; i < int'(LANES); i++) begin
            if (bus.wmask[i]) rd[p][i] = bus.wd[i];
          end
        end
      end
    end
  end

  assign bus.ready = run;
  assign bus.rd1   = rd[0];
  assign bus.rd2   = rd[1];
  assign bus.busy1 = busy[0];
  assign bus.busy2 = busy[1];
endmodule

// File: tb/tb_vec_regfile_mp.sv
// Self-checking bench: two instances (bypass/no-zero and no-bypass/zero-r0) driven in lockstep
// and compared each cycle against a behavioural register-file model.
module tb_vec_regfile_mp;
  localparam int unsigned LANES = 6;
  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 10;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned VW    = LANES * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             clear_req, we, busy_set;
  logic [AW-1:0]    wa, ra1, ra2, busy_addr;
  logic [VW-1:0]    wd;
  logic [LANES-1:0] wmask;

  vec_regfile_mp_if #(.LANES(LANES), .W(W), .DEPTH(DEPTH)) ifa ();
  vec_regfile_mp_if #(.LANES(LANES), .W(W), .DEPTH(DEPTH)) ifb ();

  vec_regfile_mp #(.LANES(LANES), .W(W), .DEPTH(DEPTH), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  vec_regfile_mp #(.LANES(LANES), .W(W), .DEPTH(DEPTH), .BYPASS(1'b0), .ZERO_R0(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  assign ifa.clear_req = clear_req;  assign ifb.clear_req = clear_req;
  assign ifa.we        = we;         assign ifb.we        = we;
  assign ifa.wa        = wa;         assign ifb.wa        = wa;
  assign ifa.wd        = wd;         assign ifb.wd        = wd;
  assign ifa.wmask     = wmask;      assign ifb.wmask     = wmask;
  assign ifa.ra1       = ra1;        assign ifb.ra1       = ra1;
  assign ifa.ra2       = ra2;        assign ifb.ra2       = ra2;
  assign ifa.busy_set  = busy_set;   assign ifb.busy_set  = busy_set;
  assign ifa.busy_addr = busy_addr;  assign ifb.busy_addr = busy_addr;

  logic [VW-1:0] o_rd1 [2];
  logic [VW-1:0] o_rd2 [2];
  logic          o_rdy [2];
  logic          o_b1  [2];
  logic          o_b2  [2];
  assign o_rd1[0] = ifa.rd1;   assign o_rd1[1] = ifb.rd1;
  assign o_rd2[0] = ifa.rd2;   assign o_rd2[1] = ifb.rd2;
  assign o_rdy[0] = ifa.ready; assign o_rdy[1] = ifb.ready;
  assign o_b1[0]  = ifa.busy1; assign o_b1[1]  = ifb.busy1;
  assign o_b2[0]  = ifa.busy2; assign o_b2[1]  = ifb.busy2;

  // Model: instance 0 has bypass, instance 1 has a hard-wired zero r0.
  logic [W-1:0] m_rf    [2][DEPTH][LANES];
  bit           m_sb    [2][DEPTH];
  int           m_left  [2];
  bit           m_ready [2];
  bit           m_valid = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic chk(string tag, logic [VW-1:0] obs, logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic bit zr(int k);
    return k == 1;
  endfunction

  function automatic bit wr_legal(int k);
    return m_ready[k] && we && !clear_req && (int'(wa) < DEPTH) && !(zr(k) && wa == 0);
  endfunction

  function automatic logic [VW-1:0] exp_rd(int k, logic [AW-1:0] ra);
    logic [VW-1:0] v = '0;
    if (!m_ready[k] || int'(ra) >= DEPTH || (zr(k) && ra == 0)) return '0;
    for (int i = 0; i < int'(LANES); i++) begin
      v[i*W +: W] = m_rf[k][ra][i];
      if (k == 0 && wr_legal(k) && wa == ra && wmask[i]) v[i*W +: W] = wd[i*W +: W];
    end
    return v;
  endfunction

  function automatic logic exp_busy(int k, logic [AW-1:0] ra);
    if (!m_ready[k] || int'(ra) >= DEPTH) return 1'b0;
    return m_sb[k][ra];
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_ready[k] = 1'b0;
        m_left[k]  = DEPTH;
        for (int r = 0; r < int'(DEPTH); r++) m_sb[k][r] = 1'b0;
      end else if (!m_ready[k]) begin
        for (int i = 0; i < int'(LANES); i++) m_rf[k][DEPTH - m_left[k]][i] = '0;
        m_left[k]--;
        if (m_left[k] == 0) m_ready[k] = 1'b1;
      end else if (clear_req) begin
        m_ready[k] = 1'b0;
        m_left[k]  = DEPTH;
        for (int r = 0; r < int'(DEPTH); r++) m_sb[k][r] = 1'b0;
      end else begin
        if (wr_legal(k)) begin
          for (int i = 0; i < int'(LANES); i++)
            if (wmask[i]) m_rf[k][wa][i] = wd[i*W +: W];
          m_sb[k][wa] = 1'b0;
        end
        if (busy_set && int'(busy_addr) < DEPTH && !(zr(k) && busy_addr == 0))
          m_sb[k][busy_addr] = 1'b1;
      end
    end
    m_valid = 1'b1;
  endtask

  task automatic check_all();
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        chk1($sformatf("ready[%0d]", k), o_rdy[k], m_ready[k]);
        chk($sformatf("rd1[%0d]", k), o_rd1[k], exp_rd(k, ra1));
        chk($sformatf("rd2[%0d]", k), o_rd2[k], exp_rd(k, ra2));
        chk1($sformatf("busy1[%0d]", k), o_b1[k], exp_busy(k, ra1));
        chk1($sformatf("busy2[%0d]", k), o_b2[k], exp_busy(k, ra2));
      end
    end
  endtask

  // Inputs change just after negedge; outputs checked 1ns later; model advances on posedge.
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic sweep_ready(string tag);
    for (int e = 1; e <= int'(DEPTH); e++) begin
      if (e == 4) clear_req = 1'b1;
      cycle();
      clear_req = 1'b0;
      #1;
      chk1({tag, "_a"}, o_rdy[0], e == int'(DEPTH));
      chk1({tag, "_b"}, o_rdy[1], e == int'(DEPTH));
    end
  endtask

  initial begin
    rst_n = 1'b0; clear_req = 1'b0; we = 1'b0; wa = '0; wd = '0; wmask = '0;
    ra1 = '0; ra2 = '0; busy_set = 1'b0; busy_addr = '0;
    @(negedge clk);

    // Reset and initial sweep
    cycle(); cycle();
    rst_n = 1'b1;
    for (int e = 1; e <= int'(DEPTH); e++) begin
      cycle();
      #1;
      chk1("ready_edge", o_rdy[0], e == int'(DEPTH));
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      ra1 = AW'(i);
      #1;
      chk("clr_rd1_a", o_rd1[0], '0);
      chk("clr_rd1_b", o_rd1[1], '0);
      chk1("clr_busy1", o_b1[0], 1'b0);
    end

    // Masked write
    we = 1'b1; wa = AW'(3); wd = {LANES{8'h55}}; wmask = '1;
    cycle();
    wd = {LANES{8'hAA}}; wmask = 6'b000101;
    cycle();
    we = 1'b0; ra1 = AW'(3);
    #1;
    chk("mask_a", o_rd1[0], 48'h5555_55AA_55AA);
    chk("mask_b", o_rd1[1], 48'h5555_55AA_55AA);

    // Bypass versus registered read
    ra2 = AW'(5); we = 1'b1; wa = AW'(5); wd = {LANES{8'h11}}; wmask = '1;
    #1;
    chk("byp_a", o_rd2[0], {LANES{8'h11}});
    chk("nobyp_b", o_rd2[1], '0);
    cycle();
    we = 1'b0;
    #1;
    chk("post_a", o_rd2[0], {LANES{8'h11}});
    chk("post_b", o_rd2[1], {LANES{8'h11}});

    // Scoreboard set / clear / set-wins
    busy_set = 1'b1; busy_addr = AW'(7); ra1 = AW'(7);
    #1;
    chk1("sb_pre", o_b1[0], 1'b0);
    cycle();
    busy_set = 1'b0;
    #1;
    chk1("sb_set_a", o_b1[0], 1'b1);
    chk1("sb_set_b", o_b1[1], 1'b1);
    we = 1'b1; wa = AW'(7); wd = {LANES{8'h77}}; wmask = '0;
    #1;
    chk1("sb_nobyp", o_b1[0], 1'b1);
    cycle();
    we = 1'b0;
    #1;
    chk1("sb_clr_a", o_b1[0], 1'b0);
    chk1("sb_clr_b", o_b1[1], 1'b0);
    busy_set = 1'b1; busy_addr = AW'(7); we = 1'b1; wa = AW'(7); wmask = '1;
    cycle();
    busy_set = 1'b0; we = 1'b0;
    #1;
    chk1("sb_win_a", o_b1[0], 1'b1);
    chk1("sb_win_b", o_b1[1], 1'b1);

    // Out-of-range and zero register
    we = 1'b1; wa = AW'(12); wd = {LANES{8'hFF}}; wmask = '1; ra1 = AW'(12); ra2 = AW'(3);
    busy_set = 1'b1; busy_addr = AW'(12);
    #1;
    chk("oor_rd1", o_rd1[0], '0);
    chk1("oor_busy1", o_b1[0], 1'b0);
    cycle();
    we = 1'b0; busy_set = 1'b0;
    #1;
    chk("oor_keep", o_rd2[0], 48'h5555_55AA_55AA);
    we = 1'b1; wa = '0; wd = {LANES{8'hFF}}; ra1 = '0; busy_set = 1'b1; busy_addr = '0;
    cycle();
    we = 1'b0; busy_set = 1'b0;
    #1;
    chk("r0_a", o_rd1[0], {LANES{8'hFF}});
    chk("r0_b", o_rd1[1], '0);
    chk1("r0_busy_a", o_b1[0], 1'b1);
    chk1("r0_busy_b", o_b1[1], 1'b0);

    // clear_req in RUN, concurrent write dropped, mid-sweep pulse ignored
    we = 1'b1; wa = AW'(4); wd = {LANES{8'h44}}; wmask = '1; busy_set = 1'b1; busy_addr = AW'(4);
    cycle();
    busy_set = 1'b0; wa = AW'(6); wd = {LANES{8'h66}};
    cycle();
    clear_req = 1'b1; wd = {LANES{8'h77}}; busy_set = 1'b1; busy_addr = AW'(6);
    ra1 = AW'(4); ra2 = AW'(6);
    cycle();
    clear_req = 1'b0; we = 1'b0; busy_set = 1'b0;
    sweep_ready("clr_ready");
    #1;
    chk("clr_r4", o_rd1[0], '0);
    chk("clr_r6", o_rd2[0], '0);
    chk1("clr_sb4", o_b1[0], 1'b0);
    chk1("clr_sb6", o_b2[0], 1'b0);

    // Reset in the middle of a sweep restarts it
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    cycle(); cycle(); cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    sweep_ready("rst_ready");

    // Randomised traffic against the model
    for (int n = 0; n < 800; n++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      clear_req = ($urandom_range(0, 79) == 0);
      we        = ($urandom_range(0, 2) != 0);
      wa        = AW'($urandom_range(0, (1 << AW) - 1));
      wd        = VW'({$urandom(), $urandom()});
      wmask     = LANES'($urandom());
      ra1       = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, (1 << AW) - 1));
      ra2       = AW'($urandom_range(0, (1 << AW) - 1));
      busy_set  = ($urandom_range(0, 2) == 0);
      busy_addr = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, (1 << AW) - 1));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
